eth_frame_buffer: RTL and testbench
===================================

// Module: eth_frame_buffer
// PURPOSE
//  Store-and-forward frame buffer. It sits on the DUT side of the Ethernet byte-stream interface and terminates both channels.
//  - Accepts frames on the tx channel and stores them.
//  - Replays each complete, length-valid frame on the rx channel.
//  - Silently drops runt and oversize frames, and flags each drop with a status pulse.
// PARAMETERS
//  DEPTH      2048  byte storage entries (data + last flag); power of 2; must exceed MAX_FRAME
//  MAX_FRAME  1518  largest accepted frame, in bytes, last byte included
//  MIN_FRAME  64    smallest accepted frame, in bytes
// PORTS
//  ETH_CLK        in   1              clock; all logic on rising edge
//  ETH_RST        in   1              synchronous reset, active-high
//  tx_valid       in   1              tx byte valid
//  tx_ready       out  1              buffer can accept a tx byte
//  tx_data        in   8              tx byte
//  tx_last        in   1              tx byte is the last of its frame
//  rx_valid       out  1              rx byte valid
//  rx_ready       in   1              downstream accepts an rx byte
//  rx_data        out  8              rx byte
//  rx_last        out  1              rx byte is the last of its frame
//  frames_stored  out  $clog2(DEPTH)+1  number of complete frames held
//  drop_runt      out  1              1-cycle pulse: a frame was dropped because length < MIN_FRAME
//  drop_oversize  out  1              1-cycle pulse: a frame was dropped because length > MAX_FRAME
// BEHAVIOUR
//  Reset and transfer rules
//  - Reset: all outputs are 0 except tx_ready, which is 1. Pointers, counts and any partial frame are cleared.
//  - Reset asserted mid-frame discards everything and takes priority over all other events.
//  - A transfer occurs on a rising edge where valid && ready; this applies to each channel independently.
//  - Throughput is 1 byte/cycle on each side, and both sides may transfer in the same cycle.
//  Write side
//  - Pointers: wr_ptr is the working write pointer; wr_commit marks the end of the last complete frame; rd_ptr is the read pointer.
//  - A length counter counts accepted bytes of the current frame, including the byte carrying tx_last.
//  - tx_ready depends only on registered state, never on tx_valid.
//  - In WRITE state: tx_ready = 1 while (wr_ptr - rd_ptr) < DEPTH; otherwise tx_ready = 0 (backpressure, no loss).
//  - If the length counter would exceed MAX_FRAME, the block enters DISCARD state:
//    - tx_ready = 1 unconditionally and bytes are not written;
//    - on the tx_last transfer, wr_ptr rewinds to wr_commit, drop_oversize pulses on the next cycle, and the block returns to WRITE.
//  - A frame of exactly MAX_FRAME bytes is accepted.
//  - On the tx_last transfer in WRITE state:
//    - length < MIN_FRAME: wr_ptr rewinds to wr_commit and drop_runt pulses on the next cycle;
//    - otherwise: wr_commit <= wr_ptr+1 and frames_stored increments.
//  Read side
//  - Read is first-word-fall-through with a registered output stage.
//  - rx_valid = 1 only when the output stage holds a byte that belongs to a committed frame.
//  - Bytes of uncommitted frames are never presented.
//  - Latency: if the buffer held no frame, rx_valid rises exactly 2 cycles after the edge that accepted a committing tx_last.
//  - While rx_valid = 1 and rx_ready = 0, rx_data and rx_last hold stable.
//  - frames_stored decrements on the rx transfer with rx_last = 1.
//  - If a commit and a final-byte read happen on the same edge, frames_stored is unchanged.
//  - Frames are delivered in arrival order, byte-exact, with rx_last exactly on the final byte.
//  - Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full: (wr_ptr - rd_ptr) == DEPTH. Empty: wr_commit == rd_ptr.
// TESTING
//  1. 64-byte frame, data 0x00..0x3F, rx_ready = 1
//     -> rx_valid rises 2 cycles after tx_last; 64 bytes are identical; rx_last on 0x3F; frames_stored goes 1 -> 0.
//  2. 63-byte frame
//     -> drop_runt pulses once; rx_valid never rises; frames_stored stays 0.
//  3. 1519-byte frame, then a 64-byte frame
//     -> tx_ready stays 1 throughout the oversize frame; drop_oversize pulses once; only the 64-byte frame appears on rx.
//  4. rx_ready = 0; send 1000-byte frames until tx_ready = 0; then set rx_ready = 1
//     -> frames_stored = 2 during the stall; all frames are delivered in order with no byte lost; tx_ready reasserts.
//  5. 1518-byte frame with a random 50% rx_ready duty cycle
//     -> every byte is delivered; rx_data and rx_last are stable while stalled.
//  6. ETH_RST asserted for 1 cycle after 30 bytes of a frame
//     -> all outputs return to reset values; the next 64-byte frame is delivered intact.

Source files
------------

// File: rtl/eth_frame_buffer.sv
// Store-and-forward Ethernet frame buffer.
// Frames arriving on the tx channel are written into a circular byte store
// and become visible to the rx channel only once their final byte has been
// accepted and the frame length is known to be legal. Runt and oversize
// frames are rewound out of the store and reported with one-cycle pulses.
module eth_frame_buffer #(
    parameter int DEPTH     = 2048,
    parameter int MAX_FRAME = 1518,
    parameter int MIN_FRAME = 64
) (
    input  logic                     ETH_CLK,
    input  logic                     ETH_RST,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    input  logic [7:0]               tx_data,
    input  logic                     tx_last,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [7:0]               rx_data,
    output logic                     rx_last,
    output logic [$clog2(DEPTH):0]   frames_stored,
    output logic                     drop_runt,
    output logic                     drop_oversize
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(MAX_FRAME + 1);

    localparam logic [LW-1:0] MAX_LEN    = LW'(MAX_FRAME);
    localparam logic [LW-1:0] RUNT_LIMIT = LW'(MIN_FRAME - 1);
    localparam logic [PW-1:0] FULL_FILL  = PW'(DEPTH);

    // Write-side states
    localparam logic [0:0] ST_WRITE   = 1'b0;
    localparam logic [0:0] ST_DISCARD = 1'b1;

    // Each entry holds {last flag, data byte}
    logic [8:0]    mem [DEPTH];

    logic [PW-1:0] wr_ptr;        // working write pointer
    logic [PW-1:0] wr_commit;     // one past the last byte of the newest complete frame
    logic [PW-1:0] wr_commit_rd;  // wr_commit as seen by the read side, one cycle later
    logic [PW-1:0] rd_ptr;        // next entry to move into the output stage
    logic [LW-1:0] frame_len;     // bytes accepted so far in the current frame
    logic [0:0]    state;

    logic [PW-1:0] fill;
    logic          tx_fire;
    logic          rx_fire;
    logic          at_max;
    logic          is_runt;
    logic          wr_accept;
    logic          commit;
    logic          runt_drop;
    logic          over_drop;
    logic          load;

    assign fill      = wr_ptr - rd_ptr;
    assign tx_ready  = (state == ST_DISCARD) || (fill < FULL_FILL);
    assign tx_fire   = tx_valid && tx_ready;
    assign rx_fire   = rx_valid && rx_ready;

    // A byte arriving when MAX_FRAME bytes are already held makes the frame oversize
    assign at_max    = (frame_len == MAX_LEN);
    // frame_len excludes the byte being accepted, hence the limit of MIN_FRAME-1
    assign is_runt   = (frame_len < RUNT_LIMIT);

    assign wr_accept = tx_fire && (state == ST_WRITE) && !at_max;
    assign commit    = wr_accept && tx_last && !is_runt;
    assign runt_drop = wr_accept && tx_last && is_runt;
    assign over_drop = tx_fire && tx_last && ((state == ST_DISCARD) || at_max);

    // Refill the output stage when it is empty or being drained this cycle
    assign load      = (!rx_valid || rx_ready) && (rd_ptr != wr_commit_rd);

    // Byte store write port
    // NOTE: the storage array has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge ETH_CLK) begin
        if (wr_accept) begin
            mem[wr_ptr[AW-1:0]] <= {tx_last, tx_data};
        end
    end

    // Write pointer, commit pointer, frame length and drop detection
    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ETH_CLK) begin
        if (ETH_RST) begin
            wr_ptr        <= '0;
            wr_commit     <= '0;
            frame_len     <= '0;
            state         <= ST_WRITE;
            drop_runt     <= 1'b0;
            drop_oversize <= 1'b0;
        end else begin
            drop_runt     <= runt_drop;
            drop_oversize <= over_drop;
            if (tx_fire) begin
                if (tx_last) begin
                    frame_len <= '0;
                    state     <= ST_WRITE;
                    if (commit) begin
                        wr_ptr    <= wr_ptr + PW'(1);
                        wr_commit <= wr_ptr + PW'(1);
                    end else begin
                        wr_ptr    <= wr_commit;
                    end
                end else if (state == ST_WRITE) begin
                    if (at_max) begin
                        state <= ST_DISCARD;
                    end else begin
                        wr_ptr    <= wr_ptr + PW'(1);
                        frame_len <= frame_len + LW'(1);
                    end
                end
            end
        end
    end

    // First-word-fall-through output stage fed from committed entries only
    always_ff @(posedge ETH_CLK) begin
        if (ETH_RST) begin
            wr_commit_rd <= '0;
            rd_ptr       <= '0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            rx_last      <= 1'b0;
        end else begin
            wr_commit_rd <= wr_commit;
            if (load) begin
                rd_ptr              <= rd_ptr + PW'(1);
                rx_valid            <= 1'b1;
                {rx_last, rx_data}  <= mem[rd_ptr[AW-1:0]];
            end else if (rx_fire) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Count of complete frames held; a simultaneous commit and final read cancel out
    always_ff @(posedge ETH_CLK) begin
        if (ETH_RST) begin
            frames_stored <= '0;
        end else begin
            case ({commit, rx_fire && rx_last})
                2'b10:   frames_stored <= frames_stored + PW'(1);
                2'b01:   frames_stored <= frames_stored - PW'(1);
                default: frames_stored <= frames_stored;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_buffer.sv
// Self-checking bench for eth_frame_buffer.
// A frame table drives single-frame cases with rx_ready held high; hand-written
// sequences cover latency, backpressure, random rx stalls and mid-frame reset.
module tb_eth_frame_buffer;

    localparam int DEPTH     = 2048;
    localparam int MAX_FRAME = 1518;
    localparam int MIN_FRAME = 64;
    localparam int TIMEOUT   = 5000;

    logic        ETH_CLK;
    logic        ETH_RST;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_last;
    logic [11:0] frames_stored;
    logic        drop_runt;
    logic        drop_oversize;

    eth_frame_buffer #(
        .DEPTH     (DEPTH),
        .MAX_FRAME (MAX_FRAME),
        .MIN_FRAME (MIN_FRAME)
    ) dut (
        .ETH_CLK       (ETH_CLK),
        .ETH_RST       (ETH_RST),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .tx_last       (tx_last),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_last       (rx_last),
        .frames_stored (frames_stored),
        .drop_runt     (drop_runt),
        .drop_oversize (drop_oversize)
    );

    initial begin
        ETH_CLK = 1'b0;
        forever #5 ETH_CLK = ~ETH_CLK;
    end

    int n_compared = 0;
    int n_mismatch = 0;

    int runt_cnt  = 0;
    int over_cnt  = 0;
    int tx_stalls = 0;

    logic [8:0] rx_q [$];
    logic [8:0] exp_q [$];

    logic       stalled = 1'b0;
    logic [8:0] held    = '0;

    typedef struct {
        int len;
        int seed;
        int exp_bytes;
        int exp_runt;
        int exp_over;
    } frame_vec_t;

    frame_vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] exp_byte(input int len, input int seed, input int i);
        return {(i == len - 1), 8'(i + seed)};
    endfunction

    task automatic expect_frame(input int len, input int seed);
        for (int i = 0; i < len; i++) exp_q.push_back(exp_byte(len, seed, i));
    endtask

    // Observe rx transfers, drop pulses and output stability away from the active edge
    always @(negedge ETH_CLK) begin
        if (!ETH_RST) begin
            if (drop_runt)     runt_cnt++;
            if (drop_oversize) over_cnt++;
            if (stalled) begin
                check("rx stall valid", 32'(rx_valid), 1);
                check("rx stall data/last", 32'({rx_last, rx_data}), 32'(held));
            end
            if (rx_valid && rx_ready) rx_q.push_back({rx_last, rx_data});
            stalled = rx_valid && !rx_ready;
            held    = {rx_last, rx_data};
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        int waits = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        while (!tx_ready && waits < TIMEOUT) begin
            tx_stalls++;
            @(posedge ETH_CLK); #1;
            waits++;
        end
        if (!tx_ready) check("tx_ready timeout", 32'(tx_ready), 1);
        @(posedge ETH_CLK); #1;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic send_frame(input int len, input int seed, input int nbytes);
        for (int i = 0; i < nbytes; i++) send_byte(8'(i + seed), (i == len - 1));
    endtask

    task automatic check_rx(input string name, input int budget);
        int errs = 0;
        int cyc  = 0;
        while (rx_q.size() < exp_q.size() && cyc < budget) begin
            @(posedge ETH_CLK); #1;
            cyc++;
        end
        repeat (4) @(posedge ETH_CLK);
        #1;
        check({name, " byte count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i]) errs++;
        end
        check({name, " byte errors"}, 32'(errs), 0);
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{len: 64,   seed: 8'h11, exp_bytes: 64,   exp_runt: 0, exp_over: 0};
        vecs[1] = '{len: 63,   seed: 8'h22, exp_bytes: 0,    exp_runt: 1, exp_over: 0};
        vecs[2] = '{len: 1,    seed: 8'h33, exp_bytes: 0,    exp_runt: 1, exp_over: 0};
        vecs[3] = '{len: 65,   seed: 8'h44, exp_bytes: 65,   exp_runt: 0, exp_over: 0};
        vecs[4] = '{len: 1519, seed: 8'h55, exp_bytes: 0,    exp_runt: 0, exp_over: 1};
        vecs[5] = '{len: 64,   seed: 8'h66, exp_bytes: 64,   exp_runt: 0, exp_over: 0};
        vecs[6] = '{len: 1518, seed: 8'h77, exp_bytes: 1518, exp_runt: 0, exp_over: 0};
        vecs[7] = '{len: 2000, seed: 8'h88, exp_bytes: 0,    exp_runt: 0, exp_over: 1};
        vecs[8] = '{len: 1517, seed: 8'h99, exp_bytes: 1517, exp_runt: 0, exp_over: 0};

        ETH_RST  = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_last  = 1'b0;
        rx_ready = 1'b0;
        repeat (3) @(posedge ETH_CLK);
        #1;
        ETH_RST = 1'b0;

        // Reset values
        check("reset tx_ready", 32'(tx_ready), 1);
        check("reset rx_valid", 32'(rx_valid), 0);
        check("reset rx_data", 32'(rx_data), 0);
        check("reset rx_last", 32'(rx_last), 0);
        check("reset frames_stored", 32'(frames_stored), 0);
        check("reset drop_runt", 32'(drop_runt), 0);
        check("reset drop_oversize", 32'(drop_oversize), 0);

        // 64-byte frame 0x00..0x3F: rx_valid rises exactly 2 cycles after tx_last
        rx_ready = 1'b1;
        send_frame(64, 0, 64);
        check("latency +0 rx_valid", 32'(rx_valid), 0);
        check("latency +0 frames_stored", 32'(frames_stored), 1);
        @(posedge ETH_CLK); #1;
        check("latency +1 rx_valid", 32'(rx_valid), 0);
        @(posedge ETH_CLK); #1;
        check("latency +2 rx_valid", 32'(rx_valid), 1);
        check("latency +2 rx_data", 32'(rx_data), 0);
        expect_frame(64, 0);
        check_rx("first frame", 200);
        check("first frame drained", 32'(frames_stored), 0);

        // Frame table with rx_ready held high
        for (int v = 0; v < 9; v++) begin
            runt_cnt  = 0;
            over_cnt  = 0;
            tx_stalls = 0;
            send_frame(vecs[v].len, vecs[v].seed, vecs[v].len);
            if (vecs[v].exp_bytes > 0) expect_frame(vecs[v].len, vecs[v].seed);
            check_rx($sformatf("vec%0d len%0d", v, vecs[v].len), 3000);
            check($sformatf("vec%0d runt pulses", v), 32'(runt_cnt), 32'(vecs[v].exp_runt));
            check($sformatf("vec%0d oversize pulses", v), 32'(over_cnt), 32'(vecs[v].exp_over));
            check($sformatf("vec%0d tx stalls", v), 32'(tx_stalls), 0);
            check($sformatf("vec%0d frames_stored", v), 32'(frames_stored), 0);
        end

        // Backpressure: three 1000-byte frames with rx stalled until tx_ready drops
        rx_ready = 1'b0;
        fork
            begin
                for (int f = 0; f < 3; f++) send_frame(1000, 10 + f * 40, 1000);
            end
            begin
                int cyc = 0;
                while (tx_ready && cyc < 4000) begin
                    @(posedge ETH_CLK); #1;
                    cyc++;
                end
                check("fill tx_ready low", 32'(tx_ready), 0);
                check("fill frames_stored", 32'(frames_stored), 2);
                @(posedge ETH_CLK); #1;
                check("fill holds tx_ready low", 32'(tx_ready), 0);
                rx_ready = 1'b1;
            end
        join
        for (int f = 0; f < 3; f++) expect_frame(1000, 10 + f * 40);
        check_rx("fill frames", 5000);
        check("fill tx_ready reasserts", 32'(tx_ready), 1);
        check("fill frames_stored drained", 32'(frames_stored), 0);

        // 1518-byte frame read with a random 50% rx_ready duty cycle
        rx_ready = 1'b0;
        fork
            send_frame(1518, 8'hA5, 1518);
            begin
                int cyc = 0;
                while (rx_q.size() < 1518 && cyc < 10000) begin
                    rx_ready = 1'($urandom_range(0, 1));
                    @(posedge ETH_CLK); #1;
                    cyc++;
                end
            end
        join
        rx_ready = 1'b1;
        expect_frame(1518, 8'hA5);
        check_rx("random stall", 200);
        check("random stall frames_stored", 32'(frames_stored), 0);

        // Reset after 30 bytes, with one complete frame still held
        rx_ready = 1'b0;
        send_frame(64, 8'h05, 64);
        send_frame(64, 8'h06, 30);
        repeat (2) @(posedge ETH_CLK);
        #1;
        check("pre-reset frames_stored", 32'(frames_stored), 1);
        ETH_RST = 1'b1;
        @(posedge ETH_CLK); #1;
        ETH_RST = 1'b0;
        check("mid reset tx_ready", 32'(tx_ready), 1);
        check("mid reset rx_valid", 32'(rx_valid), 0);
        check("mid reset rx_data", 32'(rx_data), 0);
        check("mid reset rx_last", 32'(rx_last), 0);
        check("mid reset frames_stored", 32'(frames_stored), 0);
        check("mid reset drop_runt", 32'(drop_runt), 0);
        check("mid reset drop_oversize", 32'(drop_oversize), 0);
        rx_ready = 1'b1;
        runt_cnt = 0;
        over_cnt = 0;
        send_frame(64, 8'h80, 64);
        expect_frame(64, 8'h80);
        check_rx("post reset frame", 200);
        check("post reset frames_stored", 32'(frames_stored), 0);
        check("post reset drop pulses", 32'(runt_cnt + over_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
